// File: rtl/y_stream_tx.sv
// Serial Y-stimulus transmitter: latches a WIDTH-bit word on start and shifts it out MSB-first.
// Optional even-parity trailer bit enabled by defining Y_STREAM_PARITY_EN.
module y_stream_tx #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH-1:0]           data,
    input  logic [3:0]                 div,
    output logic                       y,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bit_idx
);

    localparam int BW = $clog2(WIDTH+1);
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
    localparam logic [BW-1:0] END_IDX  = BW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef Y_STREAM_PARITY_EN
        , S_PAR
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [3:0]        div_q, div_d;
    logic [3:0]        hold_q, hold_d;
    logic              y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BW-1:0]     idx_q, idx_d;
`ifdef Y_STREAM_PARITY_EN
    logic              par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            div_q   <= '0;
            hold_q  <= '0;
            y_q     <= IDLE_LVL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
`ifdef Y_STREAM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
`ifdef Y_STREAM_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        div_d   = div_q;
        hold_d  = hold_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_d   = idx_q;
`ifdef Y_STREAM_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                y_d    = IDLE_LVL;
                busy_d = 1'b0;
                idx_d  = '0;
                if (start) begin
                    sh_d    = data;
                    div_d   = div;
                    hold_d  = div;
                    state_d = S_SHIFT;
                    busy_d  = 1'b1;
                    y_d     = data[WIDTH-1];
`ifdef Y_STREAM_PARITY_EN
                    par_d   = ^data;
`endif
                end
            end
            S_SHIFT: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else if (idx_q < LAST_IDX) begin
                    // y already shows sh_q[WIDTH-1]; the next bit is the one below it
                    sh_d   = {sh_q[WIDTH-2:0], 1'b0};
                    y_d    = sh_q[WIDTH-2];
                    idx_d  = idx_q + 1'b1;
                    hold_d = div_q;
                end else begin
                    idx_d = END_IDX;
`ifdef Y_STREAM_PARITY_EN
                    state_d = S_PAR;
                    y_d     = par_q;
                    hold_d  = div_q;
`else
                    state_d = S_IDLE;
                    y_d     = IDLE_LVL;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef Y_STREAM_PARITY_EN
            S_PAR: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                    y_d     = IDLE_LVL;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                y_d     = IDLE_LVL;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    assign y       = y_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_idx = idx_q;

endmodule

// File: tb/tb_y_stream_tx.sv
// Testbench for y_stream_tx: directed steps plus random traffic against a frame-level expected-output queue.
module tb_y_stream_tx;

    localparam int W  = 8;
    localparam int BW = $clog2(W+1);
`ifdef Y_STREAM_PARITY_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif

    logic          clk = 1'b0;
    logic          reset, start;
    logic [W-1:0]  data;
    logic [3:0]    div;
    logic          y, busy, done;
    logic [BW-1:0] bit_idx;

    always #5 clk = ~clk;

    y_stream_tx #(.WIDTH(W), .IDLE_LVL(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data), .div(div),
        .y(y), .busy(busy), .done(done), .bit_idx(bit_idx)
    );

    typedef struct packed {
        logic          y;
        logic          busy;
        logic          done;
        logic [BW-1:0] idx;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   run_len = 0;
    int   frame_len = 0;

    function automatic exp_t mk(input logic yy, input logic bb, input logic dd, input int ii);
        exp_t e;
        e.y = yy; e.busy = bb; e.done = dd; e.idx = BW'(ii);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected output for a frame: each bit held div+1 cycles, optional parity, then one done cycle.
    task automatic build_frame(input logic [W-1:0] d, input logic [3:0] dv);
        for (int k = 0; k < W; k++)
            for (int h = 0; h <= int'(dv); h++)
                q.push_back(mk(d[W-1-k], 1'b1, 1'b0, k));
        for (int p = 0; p < NP; p++)
            for (int h = 0; h <= int'(dv); h++)
                q.push_back(mk(^d, 1'b1, 1'b0, W));
        q.push_back(mk(1'b1, 1'b0, 1'b1, W));
        frame_len = (W + NP) * (int'(dv) + 1);
    endtask

    task automatic step(input logic rst, input logic st, input logic [W-1:0] d, input logic [3:0] dv);
        reset = rst; start = st; data = d; div = dv;
        @(posedge clk);
        if (rst) begin
            q.delete();
            run_len = 0;
        end else if (st && !cur.busy) begin
            build_frame(d, dv);
        end
        if (rst || q.size() == 0) cur = mk(1'b1, 1'b0, 1'b0, 0);
        else                      cur = q.pop_front();
        @(negedge clk);
        chk("y",       32'(y),       32'(cur.y));
        chk("busy",    32'(busy),    32'(cur.busy));
        chk("done",    32'(done),    32'(cur.done));
        chk("bit_idx", 32'(bit_idx), 32'(cur.idx));
        if (busy === 1'b1) run_len++;
        if (cur.done) begin
            chk("busy_len", 32'(run_len), 32'(frame_len));
            run_len = 0;
        end
    endtask

    initial begin
        logic          r_rst, r_st;
        logic [W-1:0]  r_d;
        logic [3:0]    r_dv;
        cur = mk(1'b1, 1'b0, 1'b0, 0);
        reset = 1'b1; start = 1'b0; data = '0; div = '0;

        // reset and idle
        repeat (2) step(1'b1, 1'b0, 8'h00, 4'd0);
        repeat (5) step(1'b0, 1'b0, 8'h00, 4'd0);

        // basic frame, then held bits
        step(1'b0, 1'b1, 8'hA5, 4'd0);
        repeat (10) step(1'b0, 1'b0, 8'h00, 4'd0);
        step(1'b0, 1'b1, 8'h81, 4'd2);
        repeat (30) step(1'b0, 1'b0, 8'h00, 4'd0);

        // start and data/div changes mid-frame are ignored
        step(1'b0, 1'b1, 8'hA5, 4'd1);
        repeat (5) step(1'b0, 1'b0, 8'hA5, 4'd1);
        step(1'b0, 1'b1, 8'hFF, 4'd3);
        repeat (20) step(1'b0, 1'b0, 8'hFF, 4'd3);

        // start held high: back-to-back frames
        repeat (40) step(1'b0, 1'b1, 8'h0F, 4'd0);
        repeat (12) step(1'b0, 1'b0, 8'h0F, 4'd0);

        // abort at bit 4
        step(1'b0, 1'b1, 8'h0F, 4'd0);
        repeat (4) step(1'b0, 1'b0, 8'h0F, 4'd0);
        step(1'b1, 1'b0, 8'h0F, 4'd0);
        repeat (12) step(1'b0, 1'b0, 8'h0F, 4'd0);

        // parity-relevant words
        step(1'b0, 1'b1, 8'hA5, 4'd0);
        repeat (11) step(1'b0, 1'b0, 8'h00, 4'd0);
        step(1'b0, 1'b1, 8'h07, 4'd0);
        repeat (11) step(1'b0, 1'b0, 8'h00, 4'd0);

        // slowest bit rate
        step(1'b0, 1'b1, 8'h5A, 4'd15);
        repeat (150) step(1'b0, 1'b0, 8'h00, 4'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_d   = W'($urandom);
            r_dv  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            step(r_rst, r_st, r_d, r_dv);
        end
        repeat (20) step(1'b0, 1'b0, 8'h00, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
